// File: rtl/nn_pkg.sv
// Shared types for the frame sequencer: FSM states, score type, slot math.
// Imported by nn_frame_sequencer, nn_argmax_serial and the bench.
package nn_pkg;

   localparam int NN_DW = 16;

   typedef logic signed [NN_DW-1:0] score_t;

   typedef enum logic [2:0] {
      LOAD,
      FIRE,
      WAIT,
      ARGMAX,
      HOLD
   } state_e;

   // Bit offset of slot k in a packed vector of w-bit slots.
   function automatic int unsigned slotIdx(
      input int unsigned k,
      input int unsigned w
   );
      return k * w;
   endfunction

endpackage

// File: rtl/nn_frame_sequencer_if.sv
// Pixel stream, layer-chain and result handshakes of the sequencer.
// slave = sequencer view, master = environment view.
// NN_SECOND_BEST_EN adds resSecondIndex and resMargin.
interface nn_frame_sequencer_if #(
   parameter int numInputs  = 784,
   parameter int numOutputs = 10,
   parameter int dataWidth  = 16,
   parameter int idxWidth   = $clog2(numOutputs)
);

   logic [dataWidth-1:0]            pixIn;
   logic                            pixValid;
   logic                            pixLast;
   logic                            pixReady;
   logic [dataWidth*numInputs-1:0]  coreIn;
   logic                            coreValid;
   logic [dataWidth*numOutputs-1:0] coreOut;
   logic                            coreOutValid;
   logic [idxWidth-1:0]             resIndex;
   logic [dataWidth-1:0]            resValue;
   logic                            resValid;
   logic                            resReady;
   logic                            busy;
   logic                            frameErr;
   logic                            timeoutErr;
`ifdef NN_SECOND_BEST_EN
   logic [idxWidth-1:0]             resSecondIndex;
   logic [dataWidth-1:0]            resMargin;
`endif

   modport slave (
`ifdef NN_SECOND_BEST_EN
      output resSecondIndex,
      output resMargin,
`endif
      input  pixIn,
      input  pixValid,
      input  pixLast,
      output pixReady,
      output coreIn,
      output coreValid,
      input  coreOut,
      input  coreOutValid,
      output resIndex,
      output resValue,
      output resValid,
      input  resReady,
      output busy,
      output frameErr,
      output timeoutErr
   );

   modport master (
`ifdef NN_SECOND_BEST_EN
      input  resSecondIndex,
      input  resMargin,
`endif
      output pixIn,
      output pixValid,
      output pixLast,
      input  pixReady,
      input  coreIn,
      input  coreValid,
      output coreOut,
      output coreOutValid,
      input  resIndex,
      input  resValue,
      input  resValid,
      output resReady,
      input  busy,
      input  frameErr,
      input  timeoutErr
   );

endinterface

// File: rtl/nn_argmax_serial.sv
// Serial signed argmax, one score per cycle after start_i; done_o pulses.
// Ports: start_i, scores_i in; done_o, idx_o, val_o (+sidx_o, margin_o
// when NN_SECOND_BEST_EN) out.
module nn_argmax_serial
   import nn_pkg::*;
#(
   parameter int numOutputs = 10,
   parameter int dataWidth  = 16,
   parameter int idxWidth   = $clog2(numOutputs)
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_i,
   input  logic [dataWidth*numOutputs-1:0] scores_i,
   output logic                            done_o,
   output logic [idxWidth-1:0]             idx_o,
   output logic [dataWidth-1:0]            val_o
`ifdef NN_SECOND_BEST_EN
   ,
   output logic [idxWidth-1:0]             sidx_o,
   output logic [dataWidth-1:0]            margin_o
`endif
);

   logic                        run_q;
   logic                        done_q;
   logic [idxWidth-1:0]         cnt_q;
   logic [idxWidth-1:0]         idx_q;
   logic signed [dataWidth-1:0] best_q;
   logic signed [dataWidth-1:0] cur;
   logic                        first;
   logic                        take;
   logic                        last;

   assign cur   = scores_i[slotIdx(32'(cnt_q), dataWidth) +: dataWidth];
   assign first = (cnt_q == '0);
   // strict compare: equal scores keep the lower index
   assign take  = first || (cur > best_q);
   assign last  = (cnt_q == idxWidth'(numOutputs - 1));

`ifdef NN_SECOND_BEST_EN
   logic [idxWidth-1:0]         sidx_q;
   logic signed [dataWidth-1:0] sec_q;
   logic                        sec_ok_q;
   logic signed [dataWidth:0]   diff;

   assign diff     = {best_q[dataWidth-1], best_q}
                   - {sec_q[dataWidth-1], sec_q};
   // widened difference always fits unsigned; clamp the sign side only
   assign margin_o = diff[dataWidth] ? '0 : diff[dataWidth-1:0];
   assign sidx_o   = sidx_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         idx_q    <= '0;
         best_q   <= '0;
`ifdef NN_SECOND_BEST_EN
         sidx_q   <= '0;
         sec_q    <= '0;
         sec_ok_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= '0;
         end else if (run_q) begin
            if (take) begin
               best_q <= cur;
               idx_q  <= cnt_q;
`ifdef NN_SECOND_BEST_EN
               // old best slides down to second place
               sec_q    <= best_q;
               sidx_q   <= idx_q;
               sec_ok_q <= !first;
`endif
            end
`ifdef NN_SECOND_BEST_EN
            else if (!sec_ok_q || cur > sec_q) begin
               sec_q    <= cur;
               sidx_q   <= cnt_q;
               sec_ok_q <= 1'b1;
            end
`endif
            if (last) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + idxWidth'(1);
            end
         end
      end
   end

   assign done_o = done_q;
   assign idx_o  = idx_q;
   assign val_o  = best_q;

endmodule

// File: rtl/nn_frame_sequencer.sv
// Frame loader, layer-chain launcher with timeout, serial argmax, result hold.
// Ports: clk, reset (async active-low), bus (nn_frame_sequencer_if.slave).
// NN_SECOND_BEST_EN adds second-best index and margin outputs.
module nn_frame_sequencer
   import nn_pkg::*;
#(
   parameter int numInputs     = 784,
   parameter int numOutputs    = 10,
   parameter int dataWidth     = NN_DW,
   parameter int idxWidth      = $clog2(numOutputs),
   parameter int timeoutCycles = 4096
)(
   input logic                 clk,
   input logic                 reset,
   nn_frame_sequencer_if.slave bus
);

   localparam int CW = $clog2(numInputs);
   localparam int TW = $clog2(timeoutCycles);

   logic [1:0]                      rst_sync_q;
   logic                            rst_n;
   state_e                          state_q;
   logic [CW-1:0]                   cnt_q;
   logic [TW-1:0]                   tmo_q;
   logic [dataWidth*numInputs-1:0]  frame_q;
   logic [dataWidth*numOutputs-1:0] score_q;
   logic                            pixReady_q;
   logic                            busy_q;
   logic                            coreValid_q;
   logic                            resValid_q;
   logic                            frameErr_q;
   logic                            timeoutErr_q;
   logic [idxWidth-1:0]             resIndex_q;
   logic [dataWidth-1:0]            resValue_q;
   logic                            last_slot;
   logic                            am_start;
   logic                            am_done;
   logic [idxWidth-1:0]             am_idx;
   logic [dataWidth-1:0]            am_val;
`ifdef NN_SECOND_BEST_EN
   logic [idxWidth-1:0]             am_sidx;
   logic [dataWidth-1:0]            am_margin;
   logic [idxWidth-1:0]             resSecondIndex_q;
   logic [dataWidth-1:0]            resMargin_q;
`endif

   // assert immediately, release two clocks after reset rises
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign last_slot = (cnt_q == CW'(numInputs - 1));
   assign am_start  = (state_q == WAIT) && bus.coreOutValid;

   nn_argmax_serial #(
      .numOutputs(numOutputs),
      .dataWidth (dataWidth),
      .idxWidth  (idxWidth)
   ) u_argmax (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (am_start),
      .scores_i(score_q),
      .done_o  (am_done),
      .idx_o   (am_idx),
      .val_o   (am_val)
`ifdef NN_SECOND_BEST_EN
      ,
      .sidx_o  (am_sidx),
      .margin_o(am_margin)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LOAD;
         cnt_q        <= '0;
         tmo_q        <= '0;
         frame_q      <= '0;
         score_q      <= '0;
         pixReady_q   <= 1'b1;
         busy_q       <= 1'b0;
         coreValid_q  <= 1'b0;
         resValid_q   <= 1'b0;
         frameErr_q   <= 1'b0;
         timeoutErr_q <= 1'b0;
         resIndex_q   <= '0;
         resValue_q   <= '0;
`ifdef NN_SECOND_BEST_EN
         resSecondIndex_q <= '0;
         resMargin_q      <= '0;
`endif
      end else begin
         coreValid_q  <= 1'b0;
         frameErr_q   <= 1'b0;
         timeoutErr_q <= 1'b0;
         unique case (state_q)
            LOAD: begin
               if (pixReady_q && bus.pixValid) begin
                  frame_q[slotIdx(32'(cnt_q), dataWidth) +: dataWidth]
                     <= bus.pixIn;
                  if (bus.pixLast && last_slot) begin
                     state_q     <= FIRE;
                     cnt_q       <= '0;
                     coreValid_q <= 1'b1;
                     pixReady_q  <= 1'b0;
                     busy_q      <= 1'b1;
                  end else if (bus.pixLast || last_slot) begin
                     // early or missing pixLast: restart framing
                     frameErr_q <= 1'b1;
                     cnt_q      <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            FIRE: begin
               state_q <= WAIT;
               tmo_q   <= '0;
            end
            WAIT: begin
               if (bus.coreOutValid) begin
                  score_q <= bus.coreOut;
                  state_q <= ARGMAX;
               end else if (tmo_q == TW'(timeoutCycles - 1)) begin
                  timeoutErr_q <= 1'b1;
                  state_q      <= LOAD;
                  pixReady_q   <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            ARGMAX: begin
               if (am_done) begin
                  state_q    <= HOLD;
                  resValid_q <= 1'b1;
                  resIndex_q <= am_idx;
                  resValue_q <= am_val;
`ifdef NN_SECOND_BEST_EN
                  resSecondIndex_q <= am_sidx;
                  resMargin_q      <= am_margin;
`endif
               end
            end
            HOLD: begin
               if (bus.resReady) begin
                  state_q    <= LOAD;
                  resValid_q <= 1'b0;
                  pixReady_q <= 1'b1;
                  busy_q     <= 1'b0;
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign bus.pixReady   = pixReady_q;
   assign bus.coreIn     = frame_q;
   assign bus.coreValid  = coreValid_q;
   assign bus.resIndex   = resIndex_q;
   assign bus.resValue   = resValue_q;
   assign bus.resValid   = resValid_q;
   assign bus.busy       = busy_q;
   assign bus.frameErr   = frameErr_q;
   assign bus.timeoutErr = timeoutErr_q;
`ifdef NN_SECOND_BEST_EN
   assign bus.resSecondIndex = resSecondIndex_q;
   assign bus.resMargin      = resMargin_q;
`endif

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Scoreboard bench for nn_frame_sequencer: directed frames and score sets.
// Honours NN_SECOND_BEST_EN for the extra result fields.
`timescale 1ns/1ps
module tb_nn_frame_sequencer;
   import nn_pkg::*;

   localparam int NI = 784;
   localparam int NO = 10;
   localparam int DW = 16;
   localparam int IW = 4;
   localparam int FW = NI * DW;
   localparam int SW = NO * DW;

   typedef struct {
      logic [IW-1:0] idx;
      logic [DW-1:0] val;
      logic [IW-1:0] sidx;
      logic [DW-1:0] mrg;
      int            lat;
   } res_t;

   typedef struct {
      bit tmo;
      int at;
   } err_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   nn_frame_sequencer_if #(
      .numInputs(NI), .numOutputs(NO), .dataWidth(DW), .idxWidth(IW)
   ) bus ();

   nn_frame_sequencer #(
      .numInputs(NI), .numOutputs(NO), .dataWidth(DW),
      .idxWidth(IW), .timeoutCycles(4096)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   res_t       res_q[$];
   err_t       err_q[$];
   logic [FW-1:0] frm_q[$];
   res_t       exp_r;
   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int cap_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] pixval(input int seed, input int k);
      if (seed == 0) return 16'h0100;
      return DW'(k * seed + 1);
   endfunction

   function automatic logic [FW-1:0] mkframe(input int seed);
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < NI; k++) f[k*DW +: DW] = pixval(seed, k);
      return f;
   endfunction

   // ---------------- monitor ----------------
   logic prev_cv = 0, prev_rv = 0, prev_fe = 0, prev_te = 0;

   always @(negedge clk) begin
      if (prev_cv) chk("coreValid width", bus.coreValid, 0);
      if (prev_fe) chk("frameErr width", bus.frameErr, 0);
      if (prev_te) chk("timeoutErr width", bus.timeoutErr, 0);

      if (bus.coreValid && !prev_cv) begin
         n_vec++;
         if (frm_q.size() == 0) begin
            n_bad++;
            $display("FAIL launch: coreValid with no frame expected");
         end else begin
            logic [FW-1:0] ef;
            ef = frm_q.pop_front();
            if (bus.coreIn !== ef) begin
               n_bad++;
               for (int k = 0; k < NI; k++)
                  if (bus.coreIn[k*DW +: DW] !== ef[k*DW +: DW]) begin
                     $display("FAIL coreIn slot %0d: got %h expected %h",
                              k, bus.coreIn[k*DW +: DW], ef[k*DW +: DW]);
                     break;
                  end
            end
            chk("busy at launch", bus.busy, 1);
            chk("pixReady at launch", bus.pixReady, 0);
         end
      end

      if (bus.resValid && !prev_rv) begin
         n_vec++;
         if (res_q.size() == 0) begin
            n_bad++;
            $display("FAIL result: resValid with no result expected");
         end else begin
            exp_r = res_q.pop_front();
            chk("resIndex", bus.resIndex, exp_r.idx);
            chk("resValue", bus.resValue, exp_r.val);
            chk("result latency", cyc - cap_cyc, exp_r.lat);
            chk("busy in HOLD", bus.busy, 1);
`ifdef NN_SECOND_BEST_EN
            chk("resSecondIndex", bus.resSecondIndex, exp_r.sidx);
            chk("resMargin", bus.resMargin, exp_r.mrg);
`endif
         end
      end else if (bus.resValid) begin
         chk("resIndex hold", bus.resIndex, exp_r.idx);
         chk("resValue hold", bus.resValue, exp_r.val);
         chk("pixReady in HOLD", bus.pixReady, 0);
      end

      if (bus.frameErr || bus.timeoutErr) begin
         n_vec++;
         if (err_q.size() == 0) begin
            n_bad++;
            $display("FAIL error pulse: fe=%0b te=%0b unexpected",
                     bus.frameErr, bus.timeoutErr);
         end else begin
            err_t e;
            e = err_q.pop_front();
            chk("timeoutErr", bus.timeoutErr, e.tmo);
            chk("frameErr", bus.frameErr, !e.tmo);
            chk("error cycle", cyc, e.at);
            if (e.tmo) begin
               chk("pixReady after timeout", bus.pixReady, 1);
               chk("busy after timeout", bus.busy, 0);
            end
         end
      end

      prev_cv = bus.coreValid;
      prev_rv = bus.resValid;
      prev_fe = bus.frameErr;
      prev_te = bus.timeoutErr;
   end

   // ---------------- driver ----------------
   task automatic send(input int seed, input int n, input int last_at,
                       output int lastp);
      for (int k = 0; k < n; k++) begin
         bus.pixIn    = pixval(seed, k);
         bus.pixValid = 1'b1;
         bus.pixLast  = (k == last_at);
         for (int w = 0; w < 50 && !bus.pixReady; w++) begin
            @(posedge clk); #1;
         end
         @(posedge clk); #1;
      end
      bus.pixValid = 1'b0;
      bus.pixLast  = 1'b0;
      lastp = cyc;
   endtask

   task automatic wait_launch();
      int w;
      w = 0;
      while (!bus.coreValid && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("launch seen", bus.coreValid, 1);
      @(posedge clk); #1;
   endtask

   task automatic give_scores(input logic [SW-1:0] s, input int dly);
      repeat (dly) begin @(posedge clk); #1; end
      bus.coreOut      = s;
      bus.coreOutValid = 1'b1;
      @(posedge clk); #1;
      bus.coreOutValid = 1'b0;
      cap_cyc = cyc;
   endtask

   task automatic wait_done(input int budget);
      int w;
      w = 0;
      while (!(bus.resValid && bus.resReady) && w < budget) begin
         @(posedge clk); #1;
         w++;
      end
      chk("result handshake", bus.resValid, 1);
      @(posedge clk); #1;
   endtask

   task automatic push_res(input logic [IW-1:0] i, input logic [DW-1:0] v,
                           input logic [IW-1:0] si, input logic [DW-1:0] m);
      res_t r;
      r.idx = i; r.val = v; r.sidx = si; r.mrg = m; r.lat = 11;
      res_q.push_back(r);
   endtask

   task automatic push_err(input bit t, input int at);
      err_t e;
      e.tmo = t; e.at = at;
      err_q.push_back(e);
   endtask

   logic [SW-1:0] s1, s2, s3, s4;

   initial begin
      int lp;
      s1 = {{6{16'h0000}}, 16'h0200, 16'h0200, 16'hFF00, 16'h0010};
      s2 = {16'hC000, 16'hFFEE, 16'hFFF0, 16'hFFC0, 16'h8001,
            16'hFFEF, 16'hFF80, 16'hFFE0, 16'hFF00, 16'h8000};
      s3 = {16'h0000, 16'hFFFE, 16'h0030, 16'h0010, 16'h8000,
            16'h0030, 16'h0030, 16'hFFFF, 16'h9000, 16'h0005};
      s4 = {{9{16'h8000}}, 16'h7FFF};
      bus.pixIn = '0; bus.pixValid = 0; bus.pixLast = 0;
      bus.coreOut = '0; bus.coreOutValid = 0; bus.resReady = 1;

      // reset state
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset pixReady", bus.pixReady, 1);
      chk("reset busy", bus.busy, 0);
      chk("reset coreValid", bus.coreValid, 0);
      chk("reset resValid", bus.resValid, 0);
      chk("reset frameErr", bus.frameErr, 0);
      chk("reset timeoutErr", bus.timeoutErr, 0);
      chk("reset resIndex", bus.resIndex, 0);
      chk("reset coreIn zero", bus.coreIn == '0, 1);
      reset = 1'b1;
      repeat (4) begin @(posedge clk); #1; end

      // stray coreOutValid in LOAD is ignored
      give_scores(s1, 0);
      repeat (15) begin @(posedge clk); #1; end
      chk("idle pixReady", bus.pixReady, 1);
      chk("idle busy", bus.busy, 0);

      // A: constant frame, tie scores
      frm_q.push_back(mkframe(0));
      send(0, NI, NI - 1, lp);
      wait_launch();
      push_res(4'd2, 16'h0200, 4'd3, 16'h0000);
      give_scores(s1, 0);
      wait_done(40);

      // B: early pixLast, then a back-to-back good frame, all-negative scores
      send(0, 101, 100, lp);
      push_err(1'b0, lp);
      frm_q.push_back(mkframe(3));
      send(3, NI, NI - 1, lp);
      wait_launch();
      push_res(4'd7, 16'hFFF0, 4'd4, 16'h0001);
      give_scores(s2, 0);
      wait_done(40);

      // C: mixed signs, three-way tie, late coreOutValid
      frm_q.push_back(mkframe(5));
      send(5, NI, NI - 1, lp);
      wait_launch();
      push_res(4'd3, 16'h0030, 4'd4, 16'h0000);
      give_scores(s3, 5);
      wait_done(40);

      // D: no scores -> timeout
      frm_q.push_back(mkframe(7));
      send(7, NI, NI - 1, lp);
      push_err(1'b1, lp + 4097);
      for (int w = 0; w < 4200 && err_q.size() != 0; w++) begin
         @(posedge clk); #1;
      end
      chk("timeout consumed", err_q.size(), 0);
      repeat (2) begin @(posedge clk); #1; end

      // E: result held 20 cycles with resReady low
      bus.resReady = 1'b0;
      frm_q.push_back(mkframe(11));
      send(11, NI, NI - 1, lp);
      wait_launch();
      push_res(4'd0, 16'h7FFF, 4'd1, 16'hFFFF);
      give_scores(s4, 0);
      for (int w = 0; w < 40 && !bus.resValid; w++) begin
         @(posedge clk); #1;
      end
      repeat (20) begin @(posedge clk); #1; end
      chk("held resValid", bus.resValid, 1);
      bus.resReady = 1'b1;
      wait_done(5);

      // F: reset mid-WAIT
      frm_q.push_back(mkframe(13));
      send(13, NI, NI - 1, lp);
      wait_launch();
      repeat (3) begin @(posedge clk); #1; end
      #1 reset = 1'b0;
      #1;
      chk("midreset pixReady", bus.pixReady, 1);
      chk("midreset busy", bus.busy, 0);
      chk("midreset coreValid", bus.coreValid, 0);
      chk("midreset resValid", bus.resValid, 0);
      chk("midreset resValue", bus.resValue, 0);
      chk("midreset timeoutErr", bus.timeoutErr, 0);
      chk("midreset coreIn zero", bus.coreIn == '0, 1);
`ifdef NN_SECOND_BEST_EN
      chk("midreset resMargin", bus.resMargin, 0);
`endif
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      chk("post-reset pixReady", bus.pixReady, 1);
      chk("frames all launched", frm_q.size(), 0);
      chk("results all seen", res_q.size(), 0);
      chk("errors all seen", err_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nn_frame_sequencer.md
Name: nn_frame_sequencer

Overview:
- Next-generation front/back end for the layer chain.
- Accepts a streamed frame of numInputs pixels over a valid/ready handshake and assembles the wide input vector. Fires one inference into the external layer chain, waits for its result with a timeout, then runs a serial signed argmax over a parametrised number of outputs.
- Presents the result over a valid/ready handshake.
- Replaces the fixed 10-output, free-running wide-bus interface.

Parameters:
- numInputs, 784, pixels per frame.
- numOutputs, 10, class scores from the final layer (2..256).
- dataWidth, 16, signed fixed-point width of pixels and scores.
- idxWidth, $clog2(numOutputs), width of the result index.
- timeoutCycles, 4096, maximum cycles WAIT may last before aborting.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- pixIn  in  dataWidth  pixel data.
- pixValid  in  1  pixel valid.
- pixLast  in  1  marks the final pixel of a frame.
- pixReady  out  1  sequencer accepts a pixel.
- coreIn  out  dataWidth*numInputs  assembled frame; pixel k at bits [k*dataWidth +: dataWidth].
- coreValid  out  1  one-cycle launch pulse to the layer chain.
- coreOut  in  dataWidth*numOutputs  final-layer scores.
- coreOutValid  in  1  scores valid.
- resIndex  out  idxWidth  argmax index.
- resValue  out  dataWidth  maximum score.
- resValid  out  1  result valid.
- resReady  in  1  result consumed.
- busy  out  1  high in every state except LOAD.
- frameErr  out  1  one-cycle pulse on a framing error.
- timeoutErr  out  1  one-cycle pulse on a timeout.

Behaviour:
- Reset (reset=0, async):
  - state=LOAD, pixel counter=0, coreIn=0.
  - All outputs 0 except pixReady=1.
  - Deassertion is synchronised internally by a two-flop release.
- States: LOAD -> FIRE -> WAIT -> ARGMAX -> HOLD -> LOAD.
- LOAD:
  - pixReady=1. On pixValid&pixReady, write pixIn to slot cnt and increment cnt.
  - pixLast on slot numInputs-1 -> FIRE next cycle, cnt=0.
  - Framing error, either case: pixLast on slot < numInputs-1, or slot numInputs-1 accepted without pixLast.
  - On a framing error: frameErr pulses the following cycle, cnt=0, stay in LOAD. Already-written slots are not cleared.
- FIRE:
  - coreValid=1 for exactly one cycle, pixReady=0 -> WAIT.
  - coreIn is stable from FIRE until the next LOAD write.
- WAIT:
  - Timeout counter starts at 0.
  - On coreOutValid, capture coreOut into the score register -> ARGMAX.
  - If the counter reaches timeoutCycles-1 without coreOutValid: timeoutErr pulse, go to LOAD.
  - coreOutValid in any state other than WAIT is ignored.
- ARGMAX:
  - Serial, one score per cycle, indices 0..numOutputs-1. Signed compare; strict greater-than, so the lowest index wins ties.
  - Takes numOutputs cycles, then HOLD.
  - Latency from the coreOutValid capture edge to resValid is numOutputs+1 cycles.
- HOLD:
  - resValid=1. resIndex/resValue held stable until resValid&resReady, then LOAD.
  - resReady already high on entry -> single-cycle HOLD.
  - pixReady=0 throughout HOLD.
- Simultaneous pixLast error and pixValid in the following cycle: the new pixel is accepted into slot 0.
- Reset mid-operation aborts any state immediately. No pulses are emitted on reset.

Optional Feature:
- Macro: NN_SECOND_BEST_EN.
- When defined:
  - Extra outputs resSecondIndex (idxWidth) and resMargin (dataWidth, unsigned).
  - resMargin = best - secondBest, computed in dataWidth+1 bits and then saturated to dataWidth.
  - Tracked within the same serial pass, no added latency. Ties follow the same lowest-index rule, so equal scores give margin 0.
- When undefined: the ports and second-best registers do not exist.

Decomposition:
- Package nn_pkg holds:
  - the state enum (LOAD, FIRE, WAIT, ARGMAX, HOLD);
  - the signed score typedef parameterised by dataWidth via a localparam convention;
  - the function slotIdx.
- One natural sub-module, nn_argmax_serial: start/score-in/done interface owning the running max, index and optional second best.

Test Plan:
- Stream 784 pixels of 0x0100 with pixLast on pixel 783 -> one coreValid pulse; coreIn equals 784 copies of 0x0100; busy=1.
- Scores {0x0010, 0xFF00, 0x0200, 0x0200, 0, 0, 0, 0, 0, 0} on coreOutValid -> resIndex=2, resValue=0x0200, resValid exactly 11 cycles later. With NN_SECOND_BEST_EN: resSecondIndex=3, resMargin=0.
- All scores negative, max 0xFFF0 at index 7 -> resIndex=7 (signed compare check).
- pixLast at pixel 100 -> frameErr pulse, no coreValid. A following full 784-pixel frame proceeds normally.
- No coreOutValid for 4096 cycles after FIRE -> timeoutErr pulse at cycle 4096; state LOAD, pixReady=1.
- Hold resReady=0 for 20 cycles in HOLD -> resValid and result stable, pixReady=0. Drop reset low mid-WAIT -> all outputs 0, pixReady=1 with no clock edge.
